pic_control_logic: RTL

//  Downstream consumer of the 8259A-style read/write decoder. It commits each decoded
//  ICW/OCW write into the PIC's control registers, then runs the interrupt path:
//  IR request latch (IRR), mask (IMR), fixed priority, in-service (ISR), INT and the
//  two-pulse INTA sequence. It drives vector and status bytes back to the data bus.
//  One clock. Reset is asynchronous and active-high.

---
 rtl/pic_control_logic.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pic_control_logic.sv
// 8259A-style control core: commits decoded ICW/OCW writes and runs the IRR/IMR/ISR
// priority path with the two-pulse INTA vector sequence.
module pic_control_logic #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WR_flag,
  input  logic       RD_flag,
  input  logic [2:0] WR_cur,
  input  logic       NO_ICW4,
  input  logic       A0,
  input  logic [7:0] Ds,
  input  logic [7:0] IR,
  input  logic       INTA_n,
  output logic       INT,
  output logic [7:0] Dout,
  output logic       Dout_en,
  output logic       init_done
);

  typedef enum logic [1:0] {StIdle, StWait2, StVec} inta_state_e;

  logic [1:0]                  wr_sync_q;
  logic                        wr_prev_q;
  logic [SYNC_STAGES-1:0][7:0] ir_sync_q;
  logic [7:0]                  ir_prev_q;
  logic [SYNC_STAGES-1:0]      inta_sync_q;
  logic                        inta_prev_q;

  inta_state_e state_q, state_d;
  logic [7:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [4:0]  vec_base_q, vec_base_d;
  logic        ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d, aeoi_q, aeoi_d;
  logic        rd_sel_q, rd_sel_d, init_done_q, init_done_d;
  logic [2:0]  lvl_q, lvl_d;
  logic        spur_q, spur_d;
  logic        int_q, int_d, dout_en_q, dout_en_d;
  logic [7:0]  dout_q, dout_d;

  logic       wr_commit, icw1, inta_s, inta_fall, inta_rise;
  logic [7:0] ir_s;
  logic [3:0] isr_lo;
  logic       cand_valid;
  logic [2:0] cand;

  assign wr_commit = wr_sync_q[1] & ~wr_prev_q;
  assign icw1      = wr_commit && (WR_cur == 3'd0);
  assign ir_s      = ir_sync_q[SYNC_STAGES-1];
  assign inta_s    = inta_sync_q[SYNC_STAGES-1];
  assign inta_fall = inta_prev_q & ~inta_s;
  assign inta_rise = ~inta_prev_q & inta_s;

  // isr_lo = 8 means no level in service, so every level may interrupt.
  always_comb begin
    isr_lo     = 4'd8;
    cand_valid = 1'b0;
    cand       = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (isr_q[i]) isr_lo = 4'(i);
    end
    for (int i = 7; i >= 0; i--) begin
      if (irr_q[i] && !imr_q[i] && (4'(i) < isr_lo)) begin
        cand_valid = 1'b1;
        cand       = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    irr_d       = irr_q;
    isr_d       = isr_q;
    imr_d       = imr_q;
    vec_base_d  = vec_base_q;
    ltim_d      = ltim_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    aeoi_d      = aeoi_q;
    rd_sel_d    = rd_sel_q;
    init_done_d = init_done_q;
    lvl_d       = lvl_q;
    spur_d      = spur_q;
    dout_d      = dout_q;
    dout_en_d   = 1'b0;

    if (ltim_q) irr_d = ir_s;
    else        irr_d = (irr_q | (ir_s & ~ir_prev_q)) & ir_s;

    case (state_q)
      StIdle: if (inta_fall) begin
        state_d = StWait2;
        if (cand_valid) begin
          lvl_d       = cand;
          spur_d      = 1'b0;
          isr_d[cand] = 1'b1;
          irr_d[cand] = 1'b0;
        end else begin
          lvl_d  = 3'd7;
          spur_d = 1'b1;
        end
      end
      StWait2: if (inta_fall) state_d = StVec;
      StVec: if (inta_rise) begin
        state_d = StIdle;
        if (aeoi_q && !spur_q) isr_d[lvl_q] = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // The vector owns the bus from the 2nd INTA until INTA_n returns high.
    if (state_q == StVec) begin
      dout_en_d = ~inta_rise;
    end else if (state_q == StWait2 && inta_fall) begin
      dout_d    = {vec_base_q, lvl_q};
      dout_en_d = 1'b1;
    end else begin
      dout_en_d = RD_flag;
      if (RD_flag) dout_d = A0 ? imr_q : (rd_sel_q ? isr_q : irr_q);
    end

    if (wr_commit) begin
      case (WR_cur)
        3'd0: begin
          ltim_d      = Ds[3];
          sngl_d      = Ds[1];
          ic4_d       = ~NO_ICW4;
          imr_d       = 8'h00;
          isr_d       = 8'h00;
          irr_d       = 8'h00;
          aeoi_d      = 1'b0;
          init_done_d = 1'b0;
          rd_sel_d    = 1'b0;
          state_d     = StIdle;
          dout_en_d   = 1'b0;
        end
        3'd1: begin
          vec_base_d = Ds[7:3];
          if (sngl_q && !ic4_q) init_done_d = 1'b1;
        end
        // Cascade is not supported, so ICW3 only advances the init sequence.
        3'd2: if (!ic4_q) init_done_d = 1'b1;
        3'd3: begin
          aeoi_d      = Ds[1];
          init_done_d = 1'b1;
        end
        3'd4: if (init_done_q) imr_d = Ds;
        3'd5: if (init_done_q) begin
          case (Ds[7:5])
            3'b001:  if (isr_lo != 4'd8) isr_d[isr_lo[2:0]] = 1'b0;
            3'b011:  isr_d[Ds[2:0]] = 1'b0;
            default: ;
          endcase
        end
        3'd6: if (init_done_q && Ds[1]) rd_sel_d = Ds[0];
        default: ;
      endcase
    end

    int_d = init_done_q && cand_valid && (state_q == StIdle) && !inta_fall && !icw1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync_q   <= '0;
      wr_prev_q   <= 1'b0;
      ir_sync_q   <= '0;
      ir_prev_q   <= 8'h00;
      inta_sync_q <= '0;
      inta_prev_q <= 1'b0;
      state_q     <= StIdle;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      imr_q       <= 8'hFF;
      vec_base_q  <= 5'd0;
      ltim_q      <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      aeoi_q      <= 1'b0;
      rd_sel_q    <= 1'b0;
      init_done_q <= 1'b0;
      lvl_q       <= 3'd0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      dout_q      <= 8'h00;
      dout_en_q   <= 1'b0;
    end else begin
      wr_sync_q   <= {wr_sync_q[0], WR_flag};
      wr_prev_q   <= wr_sync_q[1];
      ir_sync_q   <= {ir_sync_q[SYNC_STAGES-2:0], IR};
      ir_prev_q   <= ir_s;
      inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], INTA_n};
      inta_prev_q <= inta_s;
      state_q     <= state_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      vec_base_q  <= vec_base_d;
      ltim_q      <= ltim_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      aeoi_q      <= aeoi_d;
      rd_sel_q    <= rd_sel_d;
      init_done_q <= init_done_d;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
    end
  end

  assign INT       = int_q;
  assign Dout      = dout_q;
  assign Dout_en   = dout_en_q;
  assign init_done = init_done_q;

endmodule
